// File: rtl/vga_fb_arbiter.sv
// Framebuffer SRAM arbiter: display scan-out has absolute priority; the pixel
// writer and host reader share the remaining memory slots round-robin.
module vga_fb_arbiter #(
  parameter int ADDR_W        = 19,
  parameter int DATA_W        = 12,
  parameter int STARVE_LIMIT  = 1024,
  parameter int WR_BLANK_ONLY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_vblank,
  input  logic              i_disp_req,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic [DATA_W-1:0] o_disp_data,
  output logic              o_disp_valid,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_valid,
  output logic              o_rd_ready,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_dvalid,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_wr_starved,
  output logic              o_rd_starved,
  output logic [1:0]        o_dbg_state
);

  typedef enum logic [1:0] {
    G_IDLE = 2'd0,
    G_DISP = 2'd1,
    G_WR   = 2'd2,
    G_RD   = 2'd3
  } grant_t;

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  grant_t state, state_next, tag_q;
  logic   rr_wr_q;
  logic   wr_elig, rd_elig, grant_wr, grant_rd;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_next, rd_cnt_q, rd_cnt_next;

  // Handshake: a transfer happens in the cycle where valid & ready are both
  // high; ready is combinational and only ever raised for the granted side.
  always_comb begin
    state_next = G_IDLE;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    wr_elig    = i_wr_valid & (i_vblank | (WR_BLANK_ONLY == 0));
    rd_elig    = i_rd_valid;
    if (i_disp_req) begin
      state_next = G_DISP;
    end else if (wr_elig && (!rd_elig || rr_wr_q)) begin
      state_next = G_WR;
      grant_wr   = 1'b1;
    end else if (rd_elig) begin
      state_next = G_RD;
      grant_rd   = 1'b1;
    end
  end

  assign o_wr_ready  = grant_wr & rst_n;
  assign o_rd_ready  = grant_rd & rst_n;
  assign o_mem_en    = (state != G_IDLE);
  assign o_mem_we    = (state == G_WR);
  assign o_dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= G_IDLE;
      rr_wr_q     <= 1'b1;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else begin
      state <= state_next;
      if (grant_wr)      rr_wr_q <= 1'b0;
      else if (grant_rd) rr_wr_q <= 1'b1;
      case (state_next)
        G_DISP: begin
          o_mem_addr  <= i_disp_addr;
          o_mem_wdata <= '0;
        end
        G_WR: begin
          o_mem_addr  <= i_wr_addr;
          o_mem_wdata <= i_wr_data;
        end
        G_RD: begin
          o_mem_addr  <= i_rd_addr;
          o_mem_wdata <= '0;
        end
        default: begin
          o_mem_addr  <= '0;
          o_mem_wdata <= '0;
        end
      endcase
    end
  end

  // state is the owner tag of the address cycle; tag_q follows it into the
  // cycle where the SRAM drives read data, which is then registered out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q        <= G_IDLE;
      o_disp_data  <= '0;
      o_disp_valid <= 1'b0;
      o_rd_data    <= '0;
      o_rd_dvalid  <= 1'b0;
    end else begin
      tag_q        <= state;
      o_disp_valid <= (tag_q == G_DISP);
      o_rd_dvalid  <= (tag_q == G_RD);
      if (tag_q == G_DISP) o_disp_data <= i_mem_rdata;
      if (tag_q == G_RD)   o_rd_data   <= i_mem_rdata;
    end
  end

  always_comb begin
    wr_cnt_next = wr_cnt_q;
    rd_cnt_next = rd_cnt_q;
    if (!i_wr_valid || o_wr_ready) wr_cnt_next = '0;
    else if (wr_cnt_q != LIMIT)    wr_cnt_next = wr_cnt_q + 1'b1;
    if (!i_rd_valid || o_rd_ready) rd_cnt_next = '0;
    else if (rd_cnt_q != LIMIT)    rd_cnt_next = rd_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      o_wr_starved <= 1'b0;
      o_rd_starved <= 1'b0;
    end else begin
      wr_cnt_q     <= wr_cnt_next;
      rd_cnt_q     <= rd_cnt_next;
      o_wr_starved <= o_wr_starved | (wr_cnt_next == LIMIT);
      o_rd_starved <= o_rd_starved | (rd_cnt_next == LIMIT);
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed scenarios plus random traffic, checked
// against a reference framebuffer model through expected-response queues.
module tb_vga_fb_arbiter;

  localparam int AW  = 12;
  localparam int DW  = 12;
  localparam int LIM = 8;
  localparam int WBO = 1;

  logic          clk, rst_n;
  logic          i_vblank, i_disp_req, i_wr_valid, i_rd_valid;
  logic [AW-1:0] i_disp_addr, i_wr_addr, i_rd_addr;
  logic [DW-1:0] i_wr_data;
  logic [DW-1:0] o_disp_data, o_rd_data, o_mem_wdata, mem_rdata;
  logic          o_disp_valid, o_wr_ready, o_rd_ready, o_rd_dvalid;
  logic          o_mem_en, o_mem_we, o_wr_starved, o_rd_starved;
  logic [AW-1:0] o_mem_addr;
  logic [1:0]    dbg_state;

  vga_fb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM), .WR_BLANK_ONLY(WBO)) dut (
    .clk(clk), .rst_n(rst_n), .i_vblank(i_vblank),
    .i_disp_req(i_disp_req), .i_disp_addr(i_disp_addr),
    .o_disp_data(o_disp_data), .o_disp_valid(o_disp_valid),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .i_rd_valid(i_rd_valid), .o_rd_ready(o_rd_ready), .i_rd_addr(i_rd_addr),
    .o_rd_data(o_rd_data), .o_rd_dvalid(o_rd_dvalid),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(mem_rdata),
    .o_wr_starved(o_wr_starved), .o_rd_starved(o_rd_starved),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset / SRAM ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DW-1:0] sram    [0:(1<<AW)-1];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  always @(posedge clk)
    if (o_mem_en) begin
      if (o_mem_we) sram[o_mem_addr] <= o_mem_wdata;
      else          mem_rdata <= sram[o_mem_addr];
    end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [AW+DW:0] mem_exp_q[$];
  int             mem_due_q[$];
  logic [DW-1:0]  disp_exp_q[$];
  int             disp_due_q[$];
  logic [DW-1:0]  rd_exp_q[$];
  int             rd_due_q[$];
  bit m_wr_first, m_wr_flag, m_rd_flag;
  int m_wr_wait, m_rd_wait;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bit exp_on, wr_ok, exp_wr, exp_rd;
    logic [AW+DW:0] item;
    logic [DW-1:0] d;
    if (!rst_n) begin
      check("reset_outputs", 32'(|{o_disp_data, o_disp_valid, o_wr_ready, o_rd_ready,
            o_rd_data, o_rd_dvalid, o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata,
            o_wr_starved, o_rd_starved, dbg_state}), 32'd0);
      mem_exp_q.delete(); mem_due_q.delete();
      disp_exp_q.delete(); disp_due_q.delete();
      rd_exp_q.delete(); rd_due_q.delete();
      m_wr_first = 1'b1; m_wr_flag = 1'b0; m_rd_flag = 1'b0;
      m_wr_wait = 0; m_rd_wait = 0;
    end else begin
      exp_on = mem_due_q.size() > 0 && mem_due_q[0] == cyc;
      check("mem_en", 32'(o_mem_en), 32'(exp_on));
      if (exp_on) begin
        item = mem_exp_q.pop_front();
        void'(mem_due_q.pop_front());
        check("mem_op", 32'({o_mem_we, o_mem_addr, o_mem_wdata}), 32'(item));
      end else check("mem_we_idle", 32'(o_mem_we), 32'd0);

      exp_on = disp_due_q.size() > 0 && disp_due_q[0] == cyc;
      check("disp_valid", 32'(o_disp_valid), 32'(exp_on));
      if (exp_on) begin
        d = disp_exp_q.pop_front();
        void'(disp_due_q.pop_front());
        check("disp_data", 32'(o_disp_data), 32'(d));
      end

      exp_on = rd_due_q.size() > 0 && rd_due_q[0] == cyc;
      check("rd_dvalid", 32'(o_rd_dvalid), 32'(exp_on));
      if (exp_on) begin
        d = rd_exp_q.pop_front();
        void'(rd_due_q.pop_front());
        check("rd_data", 32'(o_rd_data), 32'(d));
      end

      check("wr_starved", 32'(o_wr_starved), 32'(m_wr_flag));
      check("rd_starved", 32'(o_rd_starved), 32'(m_rd_flag));

      // Display wins outright; otherwise the eligible side that was served
      // less recently goes first.
      wr_ok  = i_wr_valid && (i_vblank || WBO == 0);
      exp_wr = !i_disp_req && wr_ok && (!i_rd_valid || m_wr_first);
      exp_rd = !i_disp_req && i_rd_valid && !exp_wr;
      check("wr_ready", 32'(o_wr_ready), 32'(exp_wr));
      check("rd_ready", 32'(o_rd_ready), 32'(exp_rd));

      if (i_disp_req) begin
        mem_exp_q.push_back({1'b0, i_disp_addr, {DW{1'b0}}});
        mem_due_q.push_back(cyc + 1);
        disp_exp_q.push_back(ref_mem[i_disp_addr]);
        disp_due_q.push_back(cyc + 3);
      end else if (exp_wr) begin
        mem_exp_q.push_back({1'b1, i_wr_addr, i_wr_data});
        mem_due_q.push_back(cyc + 1);
        ref_mem[i_wr_addr] = i_wr_data;
        m_wr_first = 1'b0;
      end else if (exp_rd) begin
        mem_exp_q.push_back({1'b0, i_rd_addr, {DW{1'b0}}});
        mem_due_q.push_back(cyc + 1);
        rd_exp_q.push_back(ref_mem[i_rd_addr]);
        rd_due_q.push_back(cyc + 3);
        m_wr_first = 1'b1;
      end

      m_wr_wait = (i_wr_valid && !exp_wr) ? m_wr_wait + 1 : 0;
      m_rd_wait = (i_rd_valid && !exp_rd) ? m_rd_wait + 1 : 0;
      if (m_wr_wait >= LIM) m_wr_flag = 1'b1;
      if (m_rd_wait >= LIM) m_rd_flag = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_disp_req = 1'b0; i_wr_valid = 1'b0; i_rd_valid = 1'b0;
    i_disp_addr = '0; i_wr_addr = '0; i_wr_data = '0; i_rd_addr = '0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic rand_payload();
    i_wr_addr = AW'($urandom_range(0, 31));
    i_wr_data = DW'($urandom);
    i_rd_addr = AW'($urandom_range(0, 31));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b1;
    i_vblank = 1'b0;
    mem_rdata = '0;
    idle_inputs();
    for (int i = 0; i < (1 << AW); i++) begin
      sram[i]    = DW'(i + 1);
      ref_mem[i] = DW'(i + 1);
    end
    #1 rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // host read accepted, then reset lands on its address cycle
    i_rd_valid = 1'b1; i_rd_addr = AW'(5);
    tick();
    i_rd_valid = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();

    // display burst with writer and reader both pending throughout
    i_vblank = 1'b1; i_wr_valid = 1'b1; i_rd_valid = 1'b1;
    for (int i = 0; i < 640; i++) begin
      i_disp_req = 1'b1; i_disp_addr = AW'(i);
      rand_payload();
      tick();
    end
    i_disp_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rand_payload();
      tick();
    end
    idle_inputs();
    repeat (5) tick();

    // blank-only write, then readback
    do_reset(2);
    tick();
    i_vblank = 1'b0; i_wr_valid = 1'b1; i_wr_addr = AW'(12'h100); i_wr_data = DW'(12'hF00);
    repeat (4) tick();
    i_vblank = 1'b1;
    tick();
    i_wr_valid = 1'b0; i_rd_valid = 1'b1; i_rd_addr = AW'(12'h100);
    tick();
    idle_inputs();
    repeat (5) tick();

    // writer starved outside vblank, completes once vblank opens
    do_reset(2);
    i_vblank = 1'b0; i_wr_valid = 1'b1; i_wr_addr = AW'(7); i_wr_data = DW'(12'h5A5);
    repeat (10) tick();
    i_vblank = 1'b1;
    tick();
    idle_inputs();
    repeat (4) tick();

    // write followed immediately by read of the same pixel
    i_wr_valid = 1'b1; i_wr_addr = AW'(12'h0AA); i_wr_data = DW'(12'h123);
    tick();
    i_wr_valid = 1'b0; i_rd_valid = 1'b1; i_rd_addr = AW'(12'h0AA);
    tick();
    idle_inputs();
    repeat (5) tick();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      i_disp_req  = ($urandom_range(0, 3) == 0);
      i_disp_addr = AW'($urandom_range(0, 31));
      if ($urandom_range(0, 19) == 0) i_vblank = ~i_vblank;
      i_wr_valid  = ($urandom_range(0, 1) == 1);
      i_rd_valid  = ($urandom_range(0, 1) == 1);
      rand_payload();
      tick();
    end
    idle_inputs();
    repeat (6) tick();

    check("queues_drained", 32'(mem_exp_q.size() + disp_exp_q.size() + rd_exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
